ssc_dsd_decode_ctrl: RTL and testbench

Sequencing controller for the SSC/DSD decoder's error-location step. Accepts one syndrome pair per codeword over a valid/ready handshake and computes the symbol error location as the absolute difference of the two 8-bit log-domain syndromes. Classifies each codeword as no-error (NE), correctable (CE) or detected-uncorrectable (DUE), and returns the result over a backpressured output handshake. Sits between the syndrome generator and the symbol corrector, and keeps saturating CE/DUE event counters for status readout.

---
 rtl/ssc_dsd_decode_ctrl_if.sv | 28 ++
 rtl/ssc_dsd_decode_ctrl.sv | 130 +++++++++++++
 tb/tb_ssc_dsd_decode_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ssc_dsd_decode_ctrl_if.sv
// Handshake bundle between the syndrome generator, the error-location
// controller and the symbol corrector.
interface ssc_dsd_decode_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] syn0_log;
    logic [7:0] syn1_log;
    logic       syn0_zero;
    logic       syn1_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_loc;
    logic       is_ne;
    logic       is_ce;
    logic       is_due;

    // Upstream producer and downstream consumer side.
    modport master (
        output in_valid, syn0_log, syn1_log, syn0_zero, syn1_zero, out_ready,
        input  in_ready, out_valid, err_loc, is_ne, is_ce, is_due
    );

    // Controller side.
    modport slave (
        input  in_valid, syn0_log, syn1_log, syn0_zero, syn1_zero, out_ready,
        output in_ready, out_valid, err_loc, is_ne, is_ce, is_due
    );
endinterface

// File: rtl/ssc_dsd_decode_ctrl.sv
// SSC/DSD error-location controller: takes one log-domain syndrome pair,
// derives the symbol location as |s1 - s0| and classifies the codeword as
// NE / CE / DUE. Keeps saturating CE and DUE event counters.
//
// state | meaning
// IDLE  | ready for a syndrome pair, captures it on in_valid
// CALC  | classify the captured pair
// RESP  | result presented, held until out_ready
module ssc_dsd_decode_ctrl #(
    parameter int NUM_SYM = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ssc_dsd_decode_ctrl_if.slave     bus,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         ce_cnt,
    output logic [CNT_W-1:0]         due_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [8:0] NUM_SYM_L = 9'(NUM_SYM);

    state_t     state;
    logic [7:0] s0_q;
    logic [7:0] s1_q;
    logic       z0_q;
    logic       z1_q;
    logic [7:0] diff;
    logic       in_range;
    logic       handshake;

    // Location candidate from the captured pair; subtraction order avoids wrap.
    always_comb begin
        diff     = (s1_q > s0_q) ? (s1_q - s0_q) : (s0_q - s1_q);
        in_range = ({1'b0, diff} < NUM_SYM_L);
    end

    assign handshake = bus.out_valid && bus.out_ready;

    // Sequencing FSM with registered handshake and result outputs.
    // in_ready comes up one clock after reset release, never during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.err_loc   <= 8'd0;
            bus.is_ne     <= 1'b0;
            bus.is_ce     <= 1'b0;
            bus.is_due    <= 1'b0;
            s0_q          <= 8'd0;
            s1_q          <= 8'd0;
            z0_q          <= 1'b0;
            z1_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        s0_q         <= bus.syn0_log;
                        s1_q         <= bus.syn1_log;
                        z0_q         <= bus.syn0_zero;
                        z1_q         <= bus.syn1_zero;
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    bus.out_valid <= 1'b1;
                    bus.err_loc   <= 8'd0;
                    bus.is_ne     <= 1'b0;
                    bus.is_ce     <= 1'b0;
                    bus.is_due    <= 1'b0;
                    if (z0_q && z1_q) begin
                        bus.is_ne <= 1'b1;
                    end else if (z0_q || z1_q) begin
                        bus.is_due <= 1'b1;
                    end else if (in_range) begin
                        bus.is_ce   <= 1'b1;
                        bus.err_loc <= diff;
                    end else begin
                        bus.is_due <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.err_loc   <= 8'd0;
                        bus.is_ne     <= 1'b0;
                        bus.is_ce     <= 1'b0;
                        bus.is_due    <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Saturating event counters; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt  <= '0;
            due_cnt <= '0;
        end else if (cnt_clr) begin
            ce_cnt  <= '0;
            due_cnt <= '0;
        end else if (handshake) begin
            if (bus.is_ce && (ce_cnt != {CNT_W{1'b1}})) begin
                ce_cnt <= ce_cnt + CNT_W'(1);
            end
            if (bus.is_due && (due_cnt != {CNT_W{1'b1}})) begin
                due_cnt <= due_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ssc_dsd_decode_ctrl.sv
// Directed plus randomized bench for ssc_dsd_decode_ctrl, built with 4-bit
// counters so saturation is reachable.
module tb_ssc_dsd_decode_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] ce_cnt;
    logic [CNT_W-1:0] due_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int m_ce     = 0;
    int m_due    = 0;

    ssc_dsd_decode_ctrl_if bus ();

    ssc_dsd_decode_ctrl #(.NUM_SYM(8), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .ce_cnt  (ce_cnt),
        .due_cnt (due_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference classification: 0 = NE, 1 = CE, 2 = DUE.
    task automatic model(input logic [7:0] s0, input logic [7:0] s1,
                         input logic z0, input logic z1,
                         output int cls, output logic [7:0] loc);
        int a, b, d;
        a = int'(s0);
        b = int'(s1);
        d = (a > b) ? a - b : b - a;
        loc = 8'd0;
        if (z0 && z1)       cls = 0;
        else if (z0 || z1)  cls = 2;
        else if (d < 8)   begin cls = 1; loc = 8'(d); end
        else                cls = 2;
    endtask

    function automatic logic [2:0] flag_vec(input int cls);
        return {cls == 0, cls == 1, cls == 2};
    endfunction

    task automatic check_result(input string tag, input int cls, input logic [7:0] loc);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_flags"}, 32'({bus.is_ne, bus.is_ce, bus.is_due}), 32'(flag_vec(cls)));
        chk({tag, "_loc"},   32'(bus.err_loc), 32'(loc));
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    // One codeword end to end; called at a negedge with the DUT idle.
    task automatic run_txn(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic z0, input logic z1, input int hold, input logic clr);
        int cls;
        logic [7:0] loc;
        model(s0, s1, z0, z1, cls, loc);
        bus.in_valid  = 1'b1;
        bus.syn0_log  = s0;
        bus.syn1_log  = s1;
        bus.syn0_zero = z0;
        bus.syn1_zero = z1;
        wait_ready(tag);
        @(negedge clk);
        // CALC: pair already captured, upstream is free to change
        bus.in_valid  = 1'b0;
        bus.syn0_log  = 8'($urandom);
        bus.syn1_log  = 8'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        chk({tag, "_calc_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_calc_ready"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check_result({tag, "_resp"}, cls, loc);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.syn0_zero = 1'($urandom_range(0, 1));
            bus.syn1_zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_result({tag, "_hold"}, cls, loc);
            chk({tag, "_hold_ce"}, 32'(ce_cnt), 32'(m_ce));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cnt_clr       = clr;
        @(negedge clk);
        bus.out_ready = 1'b0;
        cnt_clr       = 1'b0;
        if (clr) begin
            m_ce  = 0;
            m_due = 0;
        end else if (cls == 1) begin
            m_ce  = (m_ce < CMAX) ? m_ce + 1 : CMAX;
        end else if (cls == 2) begin
            m_due = (m_due < CMAX) ? m_due + 1 : CMAX;
        end
        chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_post_flags"}, 32'({bus.is_ne, bus.is_ce, bus.is_due}), 32'd0);
        chk({tag, "_post_loc"},   32'(bus.err_loc), 32'd0);
        chk({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_ce_cnt"},     32'(ce_cnt), 32'(m_ce));
        chk({tag, "_due_cnt"},    32'(due_cnt), 32'(m_due));
    endtask

    // Abort a codeword with reset in CALC (phase 0) or RESP (phase 1).
    task automatic reset_mid(input string tag, input int phase);
        bus.in_valid  = 1'b1;
        bus.syn0_log  = 8'h40;
        bus.syn1_log  = 8'h43;
        bus.syn0_zero = 1'b0;
        bus.syn1_zero = 1'b0;
        wait_ready(tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (phase == 1) begin
            @(negedge clk);
            chk({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        m_ce  = 0;
        m_due = 0;
        chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rst_flags"}, 32'({bus.is_ne, bus.is_ce, bus.is_due, bus.err_loc}), 32'd0);
        chk({tag, "_rst_cnt"},   32'({ce_cnt, due_cnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] s0, s1;
        logic       z0, z1;
        int         off;

        // Reset with random inputs
        rst_n         = 1'b0;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.syn0_log  = 8'd0;
        bus.syn1_log  = 8'd0;
        bus.syn0_zero = 1'b0;
        bus.syn1_zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            cnt_clr       = 1'($urandom_range(0, 1));
            bus.syn0_log  = 8'($urandom);
            bus.syn1_log  = 8'($urandom);
        end
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    32'({bus.is_ne, bus.is_ce, bus.is_due, bus.err_loc}), 32'd0);
        chk("rst_counters",  32'({ce_cnt, due_cnt}), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        cnt_clr       = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // CE path, both operand orders
        run_txn("ce_fwd",  8'h10, 8'h15, 1'b0, 1'b0, 0, 1'b0);
        run_txn("ce_swap", 8'h15, 8'h10, 1'b0, 1'b0, 0, 1'b0);

        // Range and zero-flag cases
        run_txn("due_range", 8'h20, 8'h28, 1'b0, 1'b0, 0, 1'b0);
        run_txn("ce_edge7",  8'h28, 8'h21, 1'b0, 1'b0, 0, 1'b0);
        run_txn("ne_both",   8'hAA, 8'h55, 1'b1, 1'b1, 0, 1'b0);
        run_txn("due_z1",    8'h10, 8'h11, 1'b0, 1'b1, 0, 1'b0);
        run_txn("due_z0",    8'h10, 8'h11, 1'b1, 1'b0, 0, 1'b0);
        run_txn("ce_equal",  8'h33, 8'h33, 1'b0, 1'b0, 0, 1'b0);

        // Backpressure
        run_txn("bp_ce",  8'h80, 8'h83, 1'b0, 1'b0, 5, 1'b0);
        run_txn("bp_due", 8'h00, 8'hFF, 1'b0, 1'b0, 5, 1'b0);

        // Saturation then clear coinciding with a CE handshake
        for (int i = 0; i < 17; i++) begin
            s0 = 8'($urandom_range(0, 247));
            s1 = s0 + 8'($urandom_range(0, 7));
            run_txn("sat_ce", s0, s1, 1'b0, 1'b0, 0, 1'b0);
        end
        chk("sat_ce_cnt", 32'(ce_cnt), 32'(CMAX));
        run_txn("clr_ce", 8'h05, 8'h01, 1'b0, 1'b0, 0, 1'b1);
        chk("clr_ce_cnt", 32'(ce_cnt), 32'd0);

        // Reset in CALC and in RESP, then a clean codeword
        run_txn("pre_rst", 8'h07, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        reset_mid("rst_calc", 0);
        reset_mid("rst_resp", 1);
        run_txn("after_rst", 8'h60, 8'h66, 1'b0, 1'b0, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            s0  = 8'($urandom);
            off = int'($urandom_range(0, 20)) - 10;
            s1  = ($urandom_range(0, 1) == 1) ? 8'(int'(s0) + off) : 8'($urandom);
            z0  = ($urandom_range(0, 5) == 0);
            z1  = ($urandom_range(0, 5) == 0);
            run_txn("rand", s0, s1, z0, z1, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
